univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_pkg.sv | 32 +++
 rtl/univ_shift_core.sv | 41 ++++
 rtl/univ_shift_reg.sv | 113 +++++++++++
 tb/tb_univ_shift_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode codes, FSM states and helpers for univ_shift_reg
// Purpose: shared mode code constants, burst FSM state type and the
//          is_shift_mode predicate used by the top level.
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN (rotate / arithmetic shift).
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Burst-eligible modes. Without the rotate feature the rotate/ASR codes
  // degrade to hold, so they must not start a burst either.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    logic r;
    r = (mode == MODE_SHR) || (mode == MODE_SHL);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    r = r || (mode == MODE_ROR) || (mode == MODE_ROL) || (mode == MODE_ASR);
`endif
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_core.sv
// rtl/univ_shift_core.sv - combinational next-state mux for the shift register
// Purpose: computes next Q from the mode code. Stage 0 is the leftmost stage;
//          a right shift moves data toward higher stage indices.
// Ports:
//   i_mode  [2:0]   mode code (MODE_* from univ_shift_reg_pkg)
//   i_q     [W-1:0] current register stages
//   i_d     [W-1:0] parallel load data
//   i_dsr           serial in for stage 0 on right shift
//   i_dsl           serial in for stage W-1 on left shift
//   o_q_nxt [W-1:0] next register stages
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN (rotate / arithmetic shift).
module univ_shift_core
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_dsr,
  input  logic             i_dsl,
  output logic [WIDTH-1:0] o_q_nxt
);

  always_comb begin
    o_q_nxt = i_q;
    case (i_mode)
      MODE_SHR:  o_q_nxt = {i_q[WIDTH-2:0], i_dsr};
      MODE_SHL:  o_q_nxt = {i_dsl, i_q[WIDTH-1:1]};
      MODE_LOAD: o_q_nxt = i_d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROR:  o_q_nxt = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_ROL:  o_q_nxt = {i_q[0], i_q[WIDTH-1:1]};
      // Stage 0 keeps its value and is also copied into stage 1.
      MODE_ASR:  o_q_nxt = {i_q[WIDTH-2:0], i_q[0]};
`endif
      default:   o_q_nxt = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst shift engine
// Purpose: 194-style universal shift register with a START/CNT burst engine.
// Ports:
//   CP          clock, rising edge
//   MR          asynchronous active-low reset
//   S     [2:0] mode select
//   START       burst request
//   CNT   [CW]  burst length, sampled with START
//   DSR / DSL   serial inputs for right / left shift
//   D     [W]   parallel load data
//   Q     [W]   register stages, Q[0] leftmost
//   SOR / SOL   serial outputs Q[W-1] / Q[0]
//   BUSY        burst in progress
//   DONE        registered one-cycle pulse after a burst
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN (rotate / arithmetic shift).
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic [2:0]       S,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [2:0]       w_core_mode;

  univ_shift_core #(.WIDTH(WIDTH)) u_core (
    .i_mode  (w_core_mode),
    .i_q     (r_q),
    .i_d     (D),
    .i_dsr   (DSR),
    .i_dsl   (DSL),
    .o_q_nxt (w_q_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_core_mode = MODE_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (START && is_shift_mode(S)) begin
          // Accepting a burst (or a zero-length one) holds Q on this edge.
          if (CNT == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_mode_nxt  = S;
            w_cnt_nxt   = CNT;
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_core_mode = S;
        end
      end
      ST_RUN: begin
        w_core_mode = r_mode;
        w_cnt_nxt   = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Q    = r_q;
  assign SOR  = r_q[WIDTH-1];
  assign SOL  = r_q[0];
  assign BUSY = (r_state == ST_RUN);
  assign DONE = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int C = 4;

  logic         CP    = 1'b0;
  logic         MR    = 1'b0;
  logic [2:0]   S     = 3'b000;
  logic         START = 1'b0;
  logic [C-1:0] CNT   = '0;
  logic         DSR   = 1'b0;
  logic         DSL   = 1'b0;
  logic [W-1:0] D     = '0;
  logic [W-1:0] Q;
  logic         SOR;
  logic         SOL;
  logic         BUSY;
  logic         DONE;

  univ_shift_reg #(.WIDTH(W), .CW(C)) dut (
    .CP    (CP),
    .MR    (MR),
    .S     (S),
    .START (START),
    .CNT   (CNT),
    .DSR   (DSR),
    .DSL   (DSL),
    .D     (D),
    .Q     (Q),
    .SOR   (SOR),
    .SOL   (SOL),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CP = ~CP;

  int checks   = 0;
  int failures = 0;

  // Reference model: stage list with stage 0 at the front, remaining burst
  // shifts, the latched burst mode and the expected DONE level.
  bit       mq[$];
  int       m_left;
  bit [2:0] m_mode;
  bit       m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit burst_ok(input bit [2:0] s);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    return s inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
`else
    return s inside {3'd1, 3'd2};
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(1'b0);
    m_left = 0;
    m_mode = 3'd0;
    m_done = 1'b0;
  endtask

  task automatic model_apply(input bit [2:0] mode, input bit dsr, input bit dsl, input bit [W-1:0] d);
    bit b;
    case (mode)
      3'd1: begin mq.push_front(dsr); b = mq.pop_back(); end
      3'd2: begin b = mq.pop_front(); mq.push_back(dsl); end
      3'd3: begin mq.delete(); for (int i = 0; i < W; i++) mq.push_back(d[i]); end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      3'd4: begin b = mq.pop_back(); mq.push_front(b); end
      3'd5: begin b = mq.pop_front(); mq.push_back(b); end
      3'd6: begin b = mq[0]; void'(mq.pop_back()); mq.push_front(b); end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] model_q();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mq[i];
    return v;
  endfunction

  task automatic compare(input string tag);
    check({tag, ".q"},    64'(Q),    64'(model_q()));
    check({tag, ".sor"},  64'(SOR),  64'(mq[W-1]));
    check({tag, ".sol"},  64'(SOL),  64'(mq[0]));
    check({tag, ".busy"}, 64'(BUSY), 64'(m_left != 0));
    check({tag, ".done"}, 64'(DONE), 64'(m_done));
  endtask

  // Called away from the clock edge with inputs already set: advance the
  // model by one edge, wait for the edge, then compare.
  task automatic step(input string tag);
    bit nd;
    nd = 1'b0;
    if (m_left != 0) begin
      model_apply(m_mode, DSR, DSL, D);
      m_left--;
      if (m_left == 0) nd = 1'b1;
    end else if (START && burst_ok(S)) begin
      if (CNT == 0) nd = 1'b1;
      else begin
        m_mode = S;
        m_left = int'(CNT);
      end
    end else begin
      model_apply(S, DSR, DSL, D);
    end
    m_done = nd;
    @(posedge CP);
    #1;
    compare(tag);
  endtask

  task automatic drive(input string tag, input logic [2:0] s, input logic st,
                       input logic [C-1:0] cnt, input logic dsr, input logic dsl,
                       input logic [W-1:0] d);
    S = s; START = st; CNT = cnt; DSR = dsr; DSL = dsl; D = d;
    step(tag);
  endtask

  task automatic reset_pulse(input string tag);
    MR = 1'b0;
    #1;
    model_reset();
    compare(tag);
    check({tag, ".qzero"}, 64'(Q), 64'd0);
    MR = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    compare("reset");
    @(negedge CP);
    MR = 1'b1;

    // Basic modes
    drive("load",  3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'b1101_0110);
    drive("shr",   3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("shl",   3'b010, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) drive("hold", 3'b000, 1'b0, 4'd0, 1'b1, 1'b1, 8'hff);
    drive("rsvd",  3'b111, 1'b0, 4'd0, 1'b1, 1'b1, 8'hff);

    // Rotate / ASR (hold when the feature is compiled out)
    drive("ld9",   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h89);
    drive("ror",   3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("ld9b",  3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h89);
    drive("rol",   3'b101, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("ld9c",  3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h89);
    drive("asr",   3'b110, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("rotst", 3'b100, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00);
    while (m_left != 0) drive("rotrun", 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("rotend", 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);

    // Burst of 3 right shifts with S toggled during the burst
    drive("ld81",  3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h81);
    drive("bst",   3'b001, 1'b1, 4'd3, 1'b0, 1'b0, 8'h00);
    drive("brun1", 3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 8'hff);
    drive("brun2", 3'b010, 1'b1, 4'd7, 1'b0, 1'b1, 8'hff);
    drive("brun3", 3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 8'hff);
    check("burst_q", 64'(Q), 64'h08);
    drive("bdone", 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);

    // Zero-length burst
    drive("cnt0",  3'b001, 1'b1, 4'd0, 1'b1, 1'b1, 8'h00);
    drive("cnt0b", 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);

    // Back-to-back bursts: START in the DONE cycle
    drive("bb1",   3'b010, 1'b1, 4'd2, 1'b0, 1'b1, 8'h00);
    drive("bb1r",  3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    drive("bb1e",  3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("bb2",   3'b001, 1'b1, 4'd2, 1'b1, 1'b0, 8'h00);
    drive("bb2r",  3'b000, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
    drive("bb2e",  3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    drive("bb2d",  3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);

    // Reset during the 2nd of 5 shifts, then a normal load
    drive("rld",   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h5a);
    drive("rst5",  3'b001, 1'b1, 4'd5, 1'b1, 1'b0, 8'h00);
    drive("rsh1",  3'b000, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
    #2;
    reset_pulse("midrst");
    drive("postld", 3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 8'h3c);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset_pulse("rndrst");
      end
      drive("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0),
            C'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
